// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
package uart_pkg;

    // Ticks per serial bit period.
    localparam int OVERSAMPLE = 16;

    // Tick index (0-based) at which the middle of a bit is reached.
    localparam int MID_SAMPLE = OVERSAMPLE / 2;

    // Width of the per-bit tick counter.
    localparam int SMP_W = $clog2(OVERSAMPLE);

    // 2-bit FSM encoding shared by receiver and transmitter state_out.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick divider: pulses tick once every TICK_DIV clocks while not cleared.
module rx_tick_gen #(
    parameter int TICK_DIV = 8
) (
    input  logic clk_slow,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("rx_tick_gen: TICK_DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;

    // Free-running 0..TICK_DIV-1 counter, held at zero while cleared.
    always_ff @(posedge clk_slow) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == TERMINAL) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == TERMINAL) && !clear;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling that writes each good byte to
// consecutive DRAM addresses and flags bad stop bits.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int          TICK_DIV  = 8,
    parameter logic [15:0] ADDR_INIT = 16'h0000
) (
    input  logic        clk_slow,
    input  logic        reset,
    input  logic        Rx,
    output logic [7:0]  data_out,
    output logic [15:0] address,
    output logic        wren,
    output logic        Rx_busy,
    output logic        frame_err,
    output logic [1:0]  state_out
);

    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(MID_SAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx;
    state_t           r_state;
    state_t           w_state_next;
    logic             w_tick;
    logic             w_mid_start;
    logic             w_bit_end;
    logic [SMP_W-1:0] r_smp;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic [15:0]      r_addr;
    logic             r_wren;
    logic             r_frame_err;
    logic             r_wait_high;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // Tick phase restarts from zero every time a frame begins.
    rx_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_slow (clk_slow),
        .reset    (reset),
        .clear    (r_state == ST_IDLE),
        .tick     (w_tick)
    );

    assign w_mid_start = w_tick && (r_smp == SMP_MID);
    assign w_bit_end   = w_tick && (r_smp == SMP_LAST);

    // FSM state register.
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx && !r_wait_high) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_mid_start) begin
                    w_state_next = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs derived from the current state.
    always_comb begin
        Rx_busy   = (r_state != ST_IDLE);
        state_out = r_state;
    end

    // Bit timing, shifting, DRAM write strobe and address advance.
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            r_smp       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_addr      <= ADDR_INIT;
            r_wren      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wren      <= 1'b0;
            r_frame_err <= 1'b0;
            // The address moves on only after the write cycle has been seen.
            if (r_wren) begin
                r_addr <= r_addr + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_smp     <= '0;
                    r_bit_cnt <= '0;
                end
                ST_START: begin
                    if (w_tick) begin
                        // Re-zero at mid start bit so later samples land mid-bit.
                        r_smp <= w_mid_start ? '0 : r_smp + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_smp <= r_smp + 1'b1;
                        if (w_bit_end) begin
                            r_shift   <= {w_rx, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_smp <= r_smp + 1'b1;
                        if (w_bit_end) begin
                            if (w_rx) begin
                                r_data_out <= r_shift;
                                r_wren     <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_smp <= '0;
                end
            endcase
        end
    end

    // After a bad stop bit the line is still low; wait for it to go high
    // before accepting another start bit.
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            r_wait_high <= 1'b0;
        end else if ((r_state == ST_STOP) && w_bit_end && !w_rx) begin
            r_wait_high <= 1'b1;
        end else if (w_rx) begin
            r_wait_high <= 1'b0;
        end
    end

    assign data_out  = r_data_out;
    assign address   = r_addr;
    assign wren      = r_wren;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized
// traffic compared against a frame-level model of expected DRAM writes.
module tb_uart_receiver;

    localparam int TICK_DIV = 2;
    localparam int BIT      = 16 * TICK_DIV;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        rx0   = 1'b1;
    logic        rx1   = 1'b1;

    logic [7:0]  dout  [2];
    logic [15:0] addr  [2];
    logic        wren  [2];
    logic        busy  [2];
    logic        ferr  [2];
    logic [1:0]  st    [2];

    always #5 clk = ~clk;

    uart_receiver #(.TICK_DIV(TICK_DIV), .ADDR_INIT(16'h0000)) dut0 (
        .clk_slow  (clk),
        .reset     (reset),
        .Rx        (rx0),
        .data_out  (dout[0]),
        .address   (addr[0]),
        .wren      (wren[0]),
        .Rx_busy   (busy[0]),
        .frame_err (ferr[0]),
        .state_out (st[0])
    );

    uart_receiver #(.TICK_DIV(TICK_DIV), .ADDR_INIT(16'hFFFF)) dut1 (
        .clk_slow  (clk),
        .reset     (reset),
        .Rx        (rx1),
        .data_out  (dout[1]),
        .address   (addr[1]),
        .wren      (wren[1]),
        .Rx_busy   (busy[1]),
        .frame_err (ferr[1]),
        .state_out (st[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed writes {dut, address, data} and frame-error pulse counts.
    logic [24:0] got_q[$];
    int          ferr_cnt[2];

    // Model state: expected writes and per-DUT address / last data / errors.
    logic [24:0] exp_q[$];
    logic [15:0] m_addr[2];
    logic [7:0]  m_last[2];
    int          m_ferr[2];

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wren[s] === 1'b1) got_q.push_back({s[0], addr[s], dout[s]});
            if (ferr[s] === 1'b1) ferr_cnt[s]++;
            if (wren[s] === 1'b1 || ferr[s] === 1'b1)
                chk($sformatf("dut%0d/wren_ferr_excl", s), {31'd0, wren[s] & ferr[s]}, 32'd0);
        end
    end

    task automatic model_reset();
        m_addr[0] = 16'h0000;
        m_addr[1] = 16'hFFFF;
        m_last[0] = 8'h00;
        m_last[1] = 8'h00;
    endtask

    task automatic model_frame(input int sel, input logic [7:0] d, input bit stop_ok);
        if (stop_ok) begin
            exp_q.push_back({sel[0], m_addr[sel], d});
            m_last[sel] = d;
            m_addr[sel] = m_addr[sel] + 16'd1;
        end else begin
            m_ferr[sel]++;
        end
    endtask

    // Compare everything observed so far with the model; receivers must be idle.
    task automatic settle(input string tag);
        logic [31:0] g;
        logic [24:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = {7'd0, got_q.pop_front()};
            else                  g = 32'hFFFF_FFFF;
            chk({tag, "/write"}, g, {7'd0, e});
        end
        chk({tag, "/extra_writes"}, got_q.size(), 32'd0);
        got_q.delete();
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s/ferr_cnt%0d", tag, s), ferr_cnt[s], m_ferr[s]);
            chk($sformatf("%s/addr%0d", tag, s), {16'd0, addr[s]}, {16'd0, m_addr[s]});
            chk($sformatf("%s/dout%0d", tag, s), {24'd0, dout[s]}, {24'd0, m_last[s]});
            chk($sformatf("%s/state%0d", tag, s), {30'd0, st[s]}, 32'd0);
            chk($sformatf("%s/busy%0d", tag, s), {31'd0, busy[s]}, 32'd0);
        end
    endtask

    task automatic hold(input int sel, input logic v, input int n);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit stop_ok);
        $display("[TB] dut%0d frame 0x%02h stop=%0d", sel, d, stop_ok);
        hold(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(sel, d[i], BIT);
        hold(sel, stop_ok, BIT);
        model_frame(sel, d, stop_ok);
        settle($sformatf("frame_%02h", d));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] partial;
        bit         ok;
        int         sel;
        int         gap;

        m_ferr[0] = 0;
        m_ferr[1] = 0;
        ferr_cnt[0] = 0;
        ferr_cnt[1] = 0;
        model_reset();

        // Reset values while reset is held.
        repeat (4) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst/wren%0d", s), {31'd0, wren[s]}, 32'd0);
            chk($sformatf("rst/ferr%0d", s), {31'd0, ferr[s]}, 32'd0);
        end
        settle("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single good frame.
        send_frame(0, 8'hA5, 1'b1);
        hold(0, 1'b1, 8);

        // False start: short low pulse, receiver must drop back to idle.
        $display("[TB] dut0 false start");
        hold(0, 1'b0, 4);
        chk("false_start/in_start", {30'd0, st[0]}, 32'd1);
        hold(0, 1'b1, 40);
        settle("false_start");

        // Bad stop bit, then a good frame lands at the same address.
        send_frame(0, 8'h3C, 1'b0);
        hold(0, 1'b1, BIT);
        send_frame(0, 8'h5A, 1'b1);
        hold(0, 1'b1, 8);

        // Address wrap on the second receiver.
        send_frame(1, 8'h11, 1'b1);
        send_frame(1, 8'h22, 1'b1);
        hold(1, 1'b1, 8);
        chk("wrap/final_addr", {16'd0, addr[1]}, 32'h0000_0001);

        // Reset in the middle of data bit 4.
        partial = 8'hE7;
        $display("[TB] dut0 reset mid-frame 0x%02h", partial);
        hold(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(0, partial[i], BIT);
        hold(0, partial[4], BIT / 2);
        chk("midreset/busy", {31'd0, busy[0]}, 32'd1);
        reset = 1'b1;
        rx0   = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset/wren", {31'd0, wren[0]}, 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        settle("midreset");
        hold(0, 1'b1, BIT);
        send_frame(0, 8'hC3, 1'b1);

        // Back-to-back frames with no idle gap.
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'hFF, 1'b1);
        send_frame(0, 8'h81, 1'b1);
        hold(0, 1'b1, 8);

        // Randomized traffic on both receivers.
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                $display("[TB] dut%0d false start", sel);
                hold(sel, 1'b0, int'($urandom_range(1, 10)));
                hold(sel, 1'b1, BIT);
                settle("rnd_false_start");
            end
            send_frame(sel, d, ok);
            if (!ok)                            gap = BIT + int'($urandom_range(0, 8));
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else                                gap = int'($urandom_range(1, 20));
            if (gap > 0) hold(sel, 1'b1, gap);
        end
        hold(0, 1'b1, BIT);
        settle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
